riscv_retire_trace: RTL and testbench

Retirement trace buffer placed directly downstream of the single-cycle core's retire port. It captures one record per retired instruction, stamps each record with a sequence number, queues records in a FIFO and drains them to a trace sink (testbench monitor, UART formatter, debug link) over a valid/ready handshake. It absorbs back-pressure from slow sinks and counts retirements lost to overflow.

---
 rtl/riscv_retire_trace_pkg.sv | 33 +++
 rtl/riscv_retire_trace_if.sv | 38 +++
 rtl/riscv_retire_trace_fifo.sv | 77 +++++++
 rtl/riscv_retire_trace.sv | 128 ++++++++++++
 tb/tb_riscv_retire_trace.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_retire_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_retire_trace_pkg
// Purpose  : Shared types and constants for the retirement trace buffer.
//            Memory fields of retire_rec_t exist only with RETIRE_TRACE_MEM_EN.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_retire_trace_pkg;

    localparam int XLEN       = 32;
    localparam int DROP_CNT_W = 16;

    // Payload of one retired instruction; the sequence number is prepended by
    // the top because its width is a per-instance parameter.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
`ifdef RETIRE_TRACE_MEM_EN
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
        logic            mem_read;
`endif
    } retire_rec_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_retire_trace_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_retire_trace_if
// Purpose  : Valid/ready trace record channel from the buffer to its sink.
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_retire_trace_if
    import riscv_retire_trace_pkg::*;
#(
    parameter int SEQ_W = 32
) ();

    logic             trace_valid;
    logic             trace_ready;
    logic [SEQ_W-1:0] tr_seq;
    logic [XLEN-1:0]  tr_pc;
    logic [XLEN-1:0]  tr_instr;
    logic [4:0]       tr_reg_addr;
    logic [XLEN-1:0]  tr_reg_data;
    logic [XLEN-1:0]  tr_mem_addr;
    logic [XLEN-1:0]  tr_mem_data;
    logic             tr_mem_wrt;
    logic             tr_mem_read;

    modport master (
        output trace_valid, tr_seq, tr_pc, tr_instr, tr_reg_addr, tr_reg_data,
               tr_mem_addr, tr_mem_data, tr_mem_wrt, tr_mem_read,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, tr_seq, tr_pc, tr_instr, tr_reg_addr, tr_reg_data,
               tr_mem_addr, tr_mem_data, tr_mem_wrt, tr_mem_read,
        output trace_ready
    );

endinterface
`default_nettype wire

// File: rtl/riscv_retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : riscv_retire_trace_fifo
// Purpose  : Generic synchronous FIFO, power-of-two depth, registered status.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_retire_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_i,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    input  wire logic                     pop_i,
    output      logic [WIDTH-1:0]         rdata_o,
    output      logic [$clog2(DEPTH):0]   count_o,
    output      logic                     full_o,
    output      logic                     empty_o
);

    localparam int              c_aw       = $clog2(DEPTH);
    localparam int              c_cw       = c_aw + 1;
    localparam logic [c_cw-1:0] c_full_cnt = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [c_cw-1:0]  w_count_nxt;

    // A push into a full FIFO is legal only when the head leaves the same edge.
    assign w_do_pop  = pop_i & ~r_empty;
    assign w_do_push = push_i & (~r_full | w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + c_cw'(1);
            2'b01:   w_count_nxt = r_count - c_cw'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_full_cnt);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset; the read port is masked while empty instead.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata_i;
    end

    assign rdata_o = r_empty ? '0 : r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign full_o  = r_full;
    assign empty_o = r_empty;

endmodule
`default_nettype wire

// File: rtl/riscv_retire_trace.sv
`default_nettype none
// ============================================================================
// Module   : riscv_retire_trace
// Purpose  : Retirement trace buffer: sequence stamping, FIFO, overflow count.
//            Define RETIRE_TRACE_MEM_EN to store and emit memory-access fields.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_retire_trace
    import riscv_retire_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 32
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,
    input  wire logic                    trace_en_i,
    input  wire logic                    update_i,
    input  wire logic [XLEN-1:0]         pc_i,
    input  wire logic [XLEN-1:0]         instr_i,
    input  wire logic [4:0]              reg_addr_i,
    input  wire logic [XLEN-1:0]         reg_data_i,
    input  wire logic [XLEN-1:0]         mem_addr_i,
    input  wire logic [XLEN-1:0]         mem_data_i,
    input  wire logic                    mem_wrt_i,
    input  wire logic                    mem_read_i,
    riscv_retire_trace_if.master         trace,
    output      logic [$clog2(DEPTH):0]  count_o,
    output      logic                    full_o,
    output      logic                    empty_o,
    output      logic                    ovf_o,
    output      logic [DROP_CNT_W-1:0]   drop_cnt_o
);

    localparam int c_pay_w = $bits(retire_rec_t);
    localparam int c_rec_w = SEQ_W + c_pay_w;

    logic [SEQ_W-1:0]      r_seq;
    logic                  r_ovf;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_want;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    retire_rec_t           w_pay_in;
    retire_rec_t           w_pay_out;
    logic [c_rec_w-1:0]    w_rec_out;

    assign w_pop  = ~w_empty & trace.trace_ready;
    assign w_want = update_i & trace_en_i;
    assign w_push = w_want & (~w_full | w_pop);
    assign w_drop = w_want & w_full & ~w_pop;

    always_comb begin
        w_pay_in          = '0;
        w_pay_in.pc       = pc_i;
        w_pay_in.instr    = instr_i;
        w_pay_in.reg_addr = reg_addr_i;
        w_pay_in.reg_data = reg_data_i;
`ifdef RETIRE_TRACE_MEM_EN
        w_pay_in.mem_addr = mem_addr_i;
        w_pay_in.mem_data = mem_data_i;
        w_pay_in.mem_wrt  = mem_wrt_i;
        w_pay_in.mem_read = mem_read_i;
`endif
    end

    // The counter tracks every retirement so gaps in tr_seq reveal lost records.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_seq      <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (update_i) r_seq <= r_seq + SEQ_W'(1);
            if (w_drop) begin
                r_ovf      <= 1'b1;
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    riscv_retire_trace_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .wdata_i ({r_seq, w_pay_in}),
        .pop_i   (w_pop),
        .rdata_o (w_rec_out),
        .count_o (count_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_pay_out         = retire_rec_t'(w_rec_out[c_pay_w-1:0]);
    assign trace.trace_valid = ~w_empty;
    assign trace.tr_seq      = w_rec_out[c_rec_w-1 -: SEQ_W];
    assign trace.tr_pc       = w_pay_out.pc;
    assign trace.tr_instr    = w_pay_out.instr;
    assign trace.tr_reg_addr = w_pay_out.reg_addr;
    assign trace.tr_reg_data = w_pay_out.reg_data;

`ifdef RETIRE_TRACE_MEM_EN
    assign trace.tr_mem_addr = w_pay_out.mem_addr;
    assign trace.tr_mem_data = w_pay_out.mem_data;
    assign trace.tr_mem_wrt  = w_pay_out.mem_wrt;
    assign trace.tr_mem_read = w_pay_out.mem_read;
`else
    logic w_unused_mem;
    assign w_unused_mem      = ^{mem_addr_i, mem_data_i, mem_wrt_i, mem_read_i};
    assign trace.tr_mem_addr = '0;
    assign trace.tr_mem_data = '0;
    assign trace.tr_mem_wrt  = 1'b0;
    assign trace.tr_mem_read = 1'b0;
`endif

    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign ovf_o      = r_ovf;
    assign drop_cnt_o = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_retire_trace.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_retire_trace
// Purpose  : Directed self-checking bench for riscv_retire_trace (DEPTH=8).
//            Memory-field expectations follow RETIRE_TRACE_MEM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_retire_trace;
    import riscv_retire_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   trace_en_i;
    logic                   update_i;
    logic [XLEN-1:0]        pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [4:0]             reg_addr_i;
    logic                   mem_wrt_i, mem_read_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   full_o, empty_o, ovf_o;
    logic [DROP_CNT_W-1:0]  drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    riscv_retire_trace_if #(.SEQ_W(SEQ_W)) trace_if ();

    riscv_retire_trace #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .trace_en_i (trace_en_i),
        .update_i   (update_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_wrt_i  (mem_wrt_i),
        .mem_read_i (mem_read_i),
        .trace      (trace_if),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .ovf_o      (ovf_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One retire cycle; payload fields are derived from pc so checks can rebuild them.
    task automatic retire(input logic en, input logic [31:0] pc);
        trace_en_i = en;
        update_i   = 1'b1;
        pc_i       = pc;
        instr_i    = {16'h1300, pc[15:0]};
        reg_addr_i = pc[6:2];
        reg_data_i = ~pc;
        step();
        update_i   = 1'b0;
        trace_en_i = 1'b1;
    endtask

    task automatic do_reset();
        update_i = 1'b0;
        trace_if.trace_ready = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        rst_i = 1'b1; trace_en_i = 1'b1; update_i = 1'b0;
        pc_i = '0; instr_i = '0; reg_data_i = '0; reg_addr_i = '0;
        mem_addr_i = '0; mem_data_i = '0; mem_wrt_i = 1'b0; mem_read_i = 1'b0;
        trace_if.trace_ready = 1'b0;
        step(); step();

        // Reset state
        check("rst_valid", trace_if.trace_valid, 0);
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full",  full_o, 0);
        check("rst_ovf",   ovf_o, 0);
        check("rst_drop",  drop_cnt_o, 0);
        check("rst_seq",   trace_if.tr_seq, 0);
        check("rst_pc",    trace_if.tr_pc, 0);
        rst_i = 1'b0;
        step();

        // Three retirements with ready=1: each record visible one cycle after push
        trace_if.trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            retire(1'b1, 32'(4 * i));
            check("t1_valid", trace_if.trace_valid, 1);
            check("t1_seq",   trace_if.tr_seq, 64'(i));
            check("t1_pc",    trace_if.tr_pc, 64'(4 * i));
            check("t1_instr", trace_if.tr_instr, {32'h0, 16'h1300, 16'(4 * i)});
            check("t1_rd",    trace_if.tr_reg_addr, 64'(i));
            check("t1_rdat",  trace_if.tr_reg_data, {32'h0, ~32'(4 * i)});
            check("t1_count", count_o, 1);
        end
        step();
        check("t1_count_end", count_o, 0);
        check("t1_empty_end", empty_o, 1);

        // Overflow: 10 retirements into a stalled sink
        do_reset();
        for (int i = 0; i < 10; i++) begin
            retire(1'b1, 32'h100 + 32'(4 * i));
            if (i == 7) check("t2_full8", full_o, 1);
        end
        check("t2_count", count_o, 8);
        check("t2_ovf",   ovf_o, 1);
        check("t2_drop",  drop_cnt_o, 2);
        trace_if.trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_drain_seq", trace_if.tr_seq, 64'(i));
            check("t2_drain_pc",  trace_if.tr_pc, 64'(32'h100 + 32'(4 * i)));
            step();
        end
        check("t2_empty", empty_o, 1);
        retire(1'b1, 32'h200);
        check("t2_next_seq", trace_if.tr_seq, 10);
        check("t2_ovf_sticky", ovf_o, 1);
        check("t2_drop_hold",  drop_cnt_o, 2);
        step();

        // Full FIFO with simultaneous push and pop for 4 cycles
        do_reset();
        for (int i = 0; i < 8; i++) retire(1'b1, 32'(4 * i));
        check("t3_full", full_o, 1);
        trace_if.trace_ready = 1'b1;
        trace_en_i = 1'b1;
        update_i   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_i = 32'(32 + 4 * i);
            check("t3_head_seq", trace_if.tr_seq, 64'(i));
            step();
            check("t3_count", count_o, 8);
            check("t3_full_hold", full_o, 1);
        end
        update_i = 1'b0;
        check("t3_drop", drop_cnt_o, 0);
        check("t3_ovf",  ovf_o, 0);
        for (int i = 4; i < 12; i++) begin
            check("t3_drain_seq", trace_if.tr_seq, 64'(i));
            step();
        end
        check("t3_empty", empty_o, 1);

        // Capture disabled for two of five retirements
        do_reset();
        retire(1'b1, 32'h0);
        retire(1'b1, 32'h4);
        retire(1'b0, 32'h8);
        retire(1'b0, 32'hC);
        retire(1'b1, 32'h10);
        check("t4_count", count_o, 3);
        check("t4_drop",  drop_cnt_o, 0);
        trace_if.trace_ready = 1'b1;
        check("t4_seq0", trace_if.tr_seq, 0);
        step();
        check("t4_seq1", trace_if.tr_seq, 1);
        step();
        check("t4_seq4", trace_if.tr_seq, 4);
        check("t4_pc4",  trace_if.tr_pc, 32'h10);
        step();
        check("t4_empty", empty_o, 1);

        // Asynchronous reset with five records queued and overflow flagged
        do_reset();
        for (int i = 0; i < 10; i++) retire(1'b1, 32'(4 * i));
        trace_if.trace_ready = 1'b1;
        step(); step(); step();
        trace_if.trace_ready = 1'b0;
        check("t5_count5", count_o, 5);
        check("t5_ovf_pre", ovf_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("t5_async_valid", trace_if.trace_valid, 0);
        check("t5_async_count", count_o, 0);
        check("t5_async_ovf",   ovf_o, 0);
        check("t5_async_drop",  drop_cnt_o, 0);
        check("t5_async_empty", empty_o, 1);
        step();
        rst_i = 1'b0;
        retire(1'b1, 32'h300);
        check("t5_post_valid", trace_if.trace_valid, 1);
        check("t5_post_seq",   trace_if.tr_seq, 0);
        trace_if.trace_ready = 1'b1;
        step();

        // Store record with memory fields
        trace_if.trace_ready = 1'b0;
        mem_addr_i = 32'h100;
        mem_data_i = 32'hDEADBEEF;
        mem_wrt_i  = 1'b1;
        mem_read_i = 1'b0;
        retire(1'b1, 32'h400);
        mem_wrt_i  = 1'b0;
        check("t6_seq", trace_if.tr_seq, 1);
        check("t6_pc",  trace_if.tr_pc, 32'h400);
`ifdef RETIRE_TRACE_MEM_EN
        check("t6_maddr", trace_if.tr_mem_addr, 32'h100);
        check("t6_mdata", trace_if.tr_mem_data, 32'hDEADBEEF);
        check("t6_mwrt",  trace_if.tr_mem_wrt, 1);
        check("t6_mread", trace_if.tr_mem_read, 0);
`else
        check("t6_maddr", trace_if.tr_mem_addr, 0);
        check("t6_mdata", trace_if.tr_mem_data, 0);
        check("t6_mwrt",  trace_if.tr_mem_wrt, 0);
        check("t6_mread", trace_if.tr_mem_read, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
